// File: rtl/clk_div_gen_if.sv
// Configuration channel of clk_div_gen: a valid/ready request carrying
// {channel, divisor, enable}, plus the error pulse for out-of-range channels.
interface clk_div_gen_if #(
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic          cfg_en;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: NCH registered 50% square waves with per-channel
// divisors, glitch-free runtime reconfiguration through a one-deep request slot.
module clk_div_gen #(
  parameter int NCH = 3,
  parameter int CW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_gen_if.slave    cfg,
  input  logic            resync,
  output logic [NCH-1:0]  clk_out,
  output logic [NCH-1:0]  tick
);

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_PEND = 1'b1
  } slot_e;

  slot_e         slot_q, slot_d;
  logic [2:0]    pch_q, pch_d;
  logic [CW-1:0] pdiv_q, pdiv_d;
  logic          pen_q, pen_d;
  logic          err_q, err_d;
  logic          accept;
  logic          bad_ch;
  logic [NCH-1:0] apply;

  assign accept        = cfg.cfg_valid && (slot_q == SLOT_FREE);
  assign bad_ch        = int'(cfg.cfg_ch) >= NCH;
  assign cfg.cfg_ready = (slot_q == SLOT_FREE);
  assign cfg.cfg_err   = err_q;

  // Request slot: filled on accept, emptied by whichever channel applies it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    slot_d = slot_q;
    pch_d  = pch_q;
    pdiv_d = pdiv_q;
    pen_d  = pen_q;
    err_d  = 1'b0;
    case (slot_q)
      SLOT_FREE: begin
        if (accept) begin
          if (bad_ch) begin
            err_d = 1'b1;
          end else begin
            slot_d = SLOT_PEND;
            pch_d  = cfg.cfg_ch;
            pdiv_d = cfg.cfg_div;
            pen_d  = cfg.cfg_en;
          end
        end
      end
      SLOT_PEND: begin
        if (|apply) slot_d = SLOT_FREE;
      end
      default: slot_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      slot_q <= SLOT_FREE;
      pch_q  <= '0;
      pdiv_q <= '0;
      pen_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      pch_q  <= pch_d;
      pdiv_q <= pdiv_d;
      pen_q  <= pen_d;
      err_q  <= err_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic          en_q, en_d;
    logic          out_q, out_d;
    logic          tick_q;
    logic          hit;
    logic          wrap;
    logic          apply_c;

    assign hit  = (slot_q == SLOT_PEND) && (pch_q == 3'(i));
    assign wrap = (cnt_q == div_q);

    // An enabled channel only takes a new setting on the edge that would raise
    // its output, so the running period always completes and no runt appears.
    always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      en_d    = en_q;
      out_d   = out_q;
      apply_c = 1'b0;
      if (!en_q) begin
        cnt_d = '0;
        out_d = 1'b0;
        if (hit) begin
          div_d   = pdiv_q;
          en_d    = pen_q;
          apply_c = 1'b1;
        end
      end else if (resync) begin
        cnt_d = '0;
        out_d = 1'b0;
      end else if (wrap) begin
        cnt_d = '0;
        out_d = ~out_q;
        if (hit && !out_q) begin
          div_d   = pdiv_q;
          en_d    = pen_q;
          out_d   = pen_q;
          apply_c = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= CW'((1 << i) - 1);
        en_q   <= 1'b1;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        en_q   <= en_d;
        out_q  <= out_d;
        tick_q <= out_d & ~out_q;
      end
    end

    assign apply[i]   = apply_c;
    assign clk_out[i] = out_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: a phase-based reference model pushes the
// expected outputs of every clock edge into a queue, compared at the falling edge.
module tb_clk_div_gen;

  localparam int NCH = 3;
  localparam int CW  = 8;

  typedef struct packed {
    logic [NCH-1:0] co;
    logic [NCH-1:0] tk;
    logic           rdy;
    logic           err;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           resync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clk_div_gen_if #(.CW(CW)) cfg_if ();

  clk_div_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (cfg_if.slave),
    .resync  (resync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: each channel tracks a phase p in [0, 2h) with output
  // (p / h) odd; h is the half-period in clk cycles.
  int   m_h [NCH];
  int   m_p [NCH];
  bit   m_en[NCH];
  bit   m_pend;
  int   m_pch;
  int   m_pdiv;
  bit   m_pen;
  bit   m_err;

  function automatic bit m_out(int i);
    return m_en[i] && (((m_p[i] / m_h[i]) % 2) == 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 1'b1;
      m_h[i]  = 1 << i;
      m_p[i]  = 0;
    end
    m_pend = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(output exp_t e);
    bit             acc;
    bit             clr;
    bit             hit;
    int             np;
    logic [NCH-1:0] old_o;
    logic [NCH-1:0] new_o;
    acc = cfg_if.cfg_valid && !m_pend;
    clr = 1'b0;
    for (int i = 0; i < NCH; i++) old_o[i] = m_out(i);
    for (int i = 0; i < NCH; i++) begin
      hit = m_pend && (m_pch == i);
      if (!m_en[i]) begin
        if (hit) begin
          m_en[i] = m_pen;
          m_h[i]  = m_pdiv + 1;
          m_p[i]  = 0;
          clr     = 1'b1;
        end
      end else if (resync) begin
        m_p[i] = 0;
      end else begin
        np = (m_p[i] + 1) % (2 * m_h[i]);
        if (hit && np == m_h[i]) begin
          clr = 1'b1;
          if (m_pen) begin
            m_h[i] = m_pdiv + 1;
            m_p[i] = m_h[i];
          end else begin
            m_en[i] = 1'b0;
            m_p[i]  = 0;
          end
        end else begin
          m_p[i] = np;
        end
      end
    end
    for (int i = 0; i < NCH; i++) new_o[i] = m_out(i);
    if (clr) m_pend = 1'b0;
    m_err = acc && (int'(cfg_if.cfg_ch) >= NCH);
    if (acc && int'(cfg_if.cfg_ch) < NCH) begin
      m_pend = 1'b1;
      m_pch  = int'(cfg_if.cfg_ch);
      m_pdiv = int'(cfg_if.cfg_div);
      m_pen  = cfg_if.cfg_en;
    end
    e.co  = new_o;
    e.tk  = new_o & ~old_o;
    e.rdy = !m_pend;
    e.err = m_err;
  endtask

  task automatic check_now(string tag, exp_t e);
    checks++;
    assert (clk_out === e.co) else begin
      failures++;
      $error("FAIL %s clk_out got=%b want=%b", tag, clk_out, e.co);
    end
    checks++;
    assert (tick === e.tk) else begin
      failures++;
      $error("FAIL %s tick got=%b want=%b", tag, tick, e.tk);
    end
    checks++;
    assert (cfg_if.cfg_ready === e.rdy) else begin
      failures++;
      $error("FAIL %s cfg_ready got=%b want=%b", tag, cfg_if.cfg_ready, e.rdy);
    end
    checks++;
    assert (cfg_if.cfg_err === e.err) else begin
      failures++;
      $error("FAIL %s cfg_err got=%b want=%b", tag, cfg_if.cfg_err, e.err);
    end
  endtask

  // One clock: inputs were set after the previous falling edge; the model
  // predicts the edge, then the DUT is sampled at the next falling edge.
  task automatic cycle(string tag);
    exp_t e;
    if (!rst_n) begin
      model_reset();
      e = '{co: '0, tk: '0, rdy: 1'b1, err: 1'b0};
    end else begin
      model_step(e);
    end
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty got=0 want=1", tag);
    end
    if (exp_q.size() != 0) check_now(tag, exp_q.pop_front());
  endtask

  task automatic run(string tag, int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  // Holds the request until the model says it is accepted, bounded.
  task automatic req(string tag, logic [2:0] ch, logic [CW-1:0] dv, logic en);
    bit acc;
    int n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = dv;
    cfg_if.cfg_en    = en;
    n = 0;
    do begin
      acc = !m_pend;
      cycle(tag);
      n++;
    end while (!acc && n < 2000);
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL %s accept timeout got=0 want=1", tag);
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    exp_t rst_e;
    rst_e = '{co: '0, tk: '0, rdy: 1'b1, err: 1'b0};
    rst_n            = 1'b0;
    resync           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_now("reset", rst_e);
    run("reset_hold", 2);

    rst_n = 1'b1;
    run("free_run", 16);

    run("align", 1);
    req("ch1_div4", 3'd1, 8'd4, 1'b1);
    run("ch1_div4_run", 30);

    req("ch2_off", 3'd2, 8'd7, 1'b0);
    run("ch2_off_run", 20);
    req("ch2_div0", 3'd2, 8'd0, 1'b1);
    run("ch2_div0_run", 10);

    req("bad_ch", 3'd3, 8'd9, 1'b1);
    run("bad_ch_run", 6);
    req("bad_ch7", 3'd7, 8'd1, 1'b0);
    run("bad_ch7_run", 3);

    req("restore_ch2", 3'd2, 8'd3, 1'b1);
    run("restore_run", 12);
    resync = 1'b1;
    cycle("resync");
    resync = 1'b0;
    run("after_resync", 10);

    req("ch0_div2", 3'd0, 8'd2, 1'b1);
    resync = 1'b1;
    cycle("resync_vs_apply");
    resync = 1'b0;
    run("resync_vs_apply_run", 12);

    req("ch1_div20", 3'd1, 8'd20, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 3'd2;
    cfg_if.cfg_div   = 8'd5;
    cfg_if.cfg_en    = 1'b0;
    run("ignored_while_busy", 2);
    cfg_if.cfg_valid = 1'b0;
    run("ch1_div20_run", 60);

    req("ch0_max", 3'd0, 8'd255, 1'b1);
    run("ch0_max_run", 1100);

    req("pend_then_reset", 3'd1, 8'd3, 1'b1);
    run("pend_hold", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", rst_e);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    run("reset2_hold", 2);
    rst_n = 1'b1;
    run("after_reset2", 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
